otter_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit for the pipelined OTTER. It replaces the bare PC/PC_MUX/IF_ID register with a PC register, a single-outstanding-request interface to the registered instruction port of Memory, and a DEPTH-entry prefetch queue. It exposes a valid/ready handshake toward decode and a one-cycle redirect input driven by execute for branches and jumps. It sits between Memory port 1 and the decode stage.

---
 rtl/otter_pipe_pkg.sv | 18 +
 rtl/otter_fetch_queue_if.sv | 33 +++
 rtl/otter_sync_fifo.sv | 66 ++++++
 rtl/otter_fetch_queue.sv | 93 +++++++++
 tb/tb_otter_fetch_queue.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared pipeline definitions for the OTTER fetch path.
// The queue entry pairs each instruction word with the PC it was fetched from.
package otter_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction targets are word aligned; the low two bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Fetch-unit bus: execute redirect, Memory port 1 and the decode handshake.
// master = fetch unit, slave = surrounding pipeline / memory.
interface otter_fetch_queue_if #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 14
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 REDIRECT;
  logic [XLEN-1:0]      REDIRECT_PC;
  logic [ADDR_BITS-1:0] IMEM_ADDR;
  logic                 IMEM_RDEN;
  logic [XLEN-1:0]      IMEM_DOUT;
  logic                 IF_VALID;
  logic [XLEN-1:0]      IF_IR;
  logic [XLEN-1:0]      IF_PC;
  logic [XLEN-1:0]      IF_PC_4;
  logic                 ID_READY;
  logic [XLEN-1:0]      FETCH_PC;
  logic [CNT_W-1:0]     QUEUE_COUNT;

  modport master (
    input  REDIRECT, REDIRECT_PC, IMEM_DOUT, ID_READY,
    output IMEM_ADDR, IMEM_RDEN, IF_VALID, IF_IR, IF_PC, IF_PC_4, FETCH_PC, QUEUE_COUNT
  );

  modport slave (
    output REDIRECT, REDIRECT_PC, IMEM_DOUT, ID_READY,
    input  IMEM_ADDR, IMEM_RDEN, IF_VALID, IF_IR, IF_PC, IF_PC_4, FETCH_PC, QUEUE_COUNT
  );

endinterface

// File: rtl/otter_sync_fifo.sv
// Generic synchronous FIFO with flush; head is visible combinationally.
// Pointers wrap explicitly so DEPTH need not be a power of two.
module otter_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entry_data [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  always_ff @(posedge CLOCK) begin
    if (RESET || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge CLOCK) begin
        if (RESET)
          data_reg <= '0;
        else if (do_push && (wr_ptr_reg == PTR_W'(gi)))
          data_reg <= push_data;
      end
      assign entry_data[gi] = data_reg;
    end
  endgenerate

  assign head  = entry_data[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER instruction fetch: PC register, single outstanding Memory read and a
// prefetch queue feeding decode, with execute-stage redirect.
module otter_fetch_queue
  import otter_pipe_pkg::*;
#(
  parameter int              XLEN      = otter_pipe_pkg::XLEN,
  parameter int              DEPTH     = 4,
  parameter int              ADDR_BITS = 14,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input logic                CLOCK,
  input logic                RESET,
  otter_fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_reg;
  logic [XLEN-1:0]  fetch_pc_next;
  logic [XLEN-1:0]  inflight_pc_reg;
  logic [XLEN-1:0]  inflight_pc_next;
  logic             inflight_reg;
  logic             inflight_next;

  logic [CNT_W-1:0] count;
  logic             empty;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [$bits(fetch_entry_t)-1:0] head_bits;

  // Queue slots are reserved at issue time, so a returning word always fits.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_reg};
  assign issue     = !RESET && !bus.REDIRECT && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight_reg && !bus.REDIRECT;
  assign pop       = !empty && bus.ID_READY && !bus.REDIRECT;

  assign push_entry = '{ir: bus.IMEM_DOUT, pc: inflight_pc_reg};
  assign head_entry = fetch_entry_t'(head_bits);

  otter_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.REDIRECT),
    .count     (count),
    .head      (head_bits),
    .empty     (empty)
  );

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = 1'b0;
    if (bus.REDIRECT) begin
      fetch_pc_next = align_word(bus.REDIRECT_PC);
    end else if (issue) begin
      fetch_pc_next    = fetch_pc_reg + XLEN'(4);
      inflight_pc_next = fetch_pc_reg;
      inflight_next    = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      fetch_pc_reg    <= RESET_VEC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_pc_reg <= inflight_pc_next;
      inflight_reg    <= inflight_next;
    end
  end

  assign bus.IMEM_ADDR   = fetch_pc_reg[ADDR_BITS+1:2];
  assign bus.IMEM_RDEN   = issue;
  assign bus.IF_VALID    = !empty;
  assign bus.IF_IR       = empty ? '0 : head_entry.ir;
  assign bus.IF_PC       = empty ? '0 : head_entry.pc;
  assign bus.IF_PC_4     = empty ? '0 : head_entry.pc + XLEN'(4);
  assign bus.FETCH_PC    = fetch_pc_reg;
  assign bus.QUEUE_COUNT = count;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: stimulus table, directed redirect/wrap/reset
// sequences, then random traffic against a queue-level reference model.
module tb_otter_fetch_queue;
  import otter_pipe_pkg::*;

  localparam int          DEPTH     = 4;
  localparam int          ADDR_BITS = 14;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam int          NV        = 23;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  otter_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) bus ();

  otter_fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .RESET_VEC(RESET_VEC)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Memory port 1: registered read, word i holds A500_0000 | i
  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return 32'hA500_0000 | {18'd0, a};
  endfunction

  logic [31:0] imem_q;
  always @(posedge clk) if (bus.IMEM_RDEN) imem_q <= mem_word(bus.IMEM_ADDR);
  assign bus.IMEM_DOUT = imem_q;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        chk;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_rden;
    logic [31:0] e_fpc;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic rdy, input logic c, input logic v,
                              input logic [31:0] pc, input int cnt, input logic rden,
                              input logic [31:0] fpc);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.chk = c; t.e_valid = v; t.e_pc = pc;
    t.e_cnt = cnt; t.e_rden = rden; t.e_fpc = fpc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst             = r;
    bus.REDIRECT    = redir;
    bus.REDIRECT_PC = rpc;
    bus.ID_READY    = rdy;
    #1;
  endtask

  task automatic expect_state(input string tag, input logic v, input logic [31:0] pc,
                              input int cnt, input logic rden, input logic [31:0] fpc);
    chk({tag, ".valid"}, 32'(bus.IF_VALID), 32'(v));
    chk({tag, ".count"}, 32'(bus.QUEUE_COUNT), cnt);
    chk({tag, ".rden"}, 32'(bus.IMEM_RDEN), 32'(rden));
    chk({tag, ".fetch_pc"}, bus.FETCH_PC, fpc);
    if (v) begin
      chk({tag, ".if_pc"}, bus.IF_PC, pc);
      chk({tag, ".if_ir"}, bus.IF_IR, mem_word(pc[15:2]));
      chk({tag, ".if_pc_4"}, bus.IF_PC_4, pc + 32'd4);
    end else begin
      chk({tag, ".if_pc_zero"}, bus.IF_PC, 32'h0);
      chk({tag, ".if_ir_zero"}, bus.IF_IR, 32'h0);
      chk({tag, ".if_pc_4_zero"}, bus.IF_PC_4, 32'h0);
    end
    $display("step %s valid=%0b pc=%h cnt=%0d rden=%0b fetch_pc=%h", tag, bus.IF_VALID,
             bus.IF_PC, bus.QUEUE_COUNT, bus.IMEM_RDEN, bus.FETCH_PC);
  endtask

  // Reference model state for the random phase
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  logic        m_infl;

  initial begin
    rst             = 1'b1;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    bus.ID_READY    = 1'b0;

    // Reset release, streaming, stall to full, release
    tbl[0] = mk(1, 0, 0, 0, 0,     0, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 0,     0, 0, 0);
    tbl[2] = mk(0, 1, 1, 0, 0,     0, 1, 32'd0);
    tbl[3] = mk(0, 1, 1, 0, 0,     0, 1, 32'd4);
    tbl[4] = mk(0, 1, 1, 1, 32'd0, 1, 1, 32'd8);
    tbl[5] = mk(0, 1, 1, 1, 32'd4, 1, 1, 32'd12);
    tbl[6] = mk(0, 1, 1, 1, 32'd8, 1, 1, 32'd16);
    tbl[7] = mk(0, 0, 1, 1, 32'd12, 1, 1, 32'd20);
    tbl[8] = mk(0, 0, 1, 1, 32'd12, 2, 1, 32'd24);
    tbl[9] = mk(0, 0, 1, 1, 32'd12, 3, 0, 32'd28);
    for (int i = 10; i < 17; i++) tbl[i] = mk(0, 0, 1, 1, 32'd12, 4, 0, 32'd28);
    tbl[17] = mk(0, 1, 1, 1, 32'd12, 4, 0, 32'd28);
    tbl[18] = mk(0, 1, 1, 1, 32'd16, 3, 1, 32'd28);
    tbl[19] = mk(0, 1, 1, 1, 32'd20, 2, 1, 32'd32);
    tbl[20] = mk(0, 1, 1, 1, 32'd24, 2, 1, 32'd36);
    tbl[21] = mk(0, 1, 1, 1, 32'd28, 2, 1, 32'd40);
    tbl[22] = mk(0, 1, 1, 1, 32'd32, 2, 1, 32'd44);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, 1'b0, 32'h0, tbl[i].rdy);
      if (tbl[i].chk)
        expect_state($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt,
                     tbl[i].e_rden, tbl[i].e_fpc);
    end

    // Redirect with three queued entries and one read in flight
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0);
    drive(0, 1, 32'h100, 0);   expect_state("redir_n",  1, 32'h0,   3, 0, 32'd16);
    drive(0, 0, 0, 0);         expect_state("redir_n1", 0, 0,       0, 1, 32'h100);
    chk("redir_n1.imem_addr", 32'(bus.IMEM_ADDR), 32'h40);
    drive(0, 0, 0, 1);         expect_state("redir_n2", 0, 0,       0, 1, 32'h104);
    drive(0, 0, 0, 1);         expect_state("redir_n3", 1, 32'h100, 1, 1, 32'h108);
    drive(0, 0, 0, 1);         expect_state("redir_n4", 1, 32'h104, 1, 1, 32'h10C);

    // Redirect coinciding with a pop, unaligned target
    drive(0, 1, 32'h103, 1);   expect_state("rpop_n",  1, 32'h108, 1, 0, 32'h110);
    drive(0, 0, 0, 1);         expect_state("rpop_n1", 0, 0,       0, 1, 32'h100);
    drive(0, 0, 0, 1);         expect_state("rpop_n2", 0, 0,       0, 1, 32'h104);
    drive(0, 0, 0, 1);         expect_state("rpop_n3", 1, 32'h100, 1, 1, 32'h108);
    drive(0, 0, 0, 1);         expect_state("rpop_n4", 1, 32'h104, 1, 1, 32'h10C);

    // PC wrap at the top of the address space
    drive(0, 1, 32'hFFFF_FFFE, 1); expect_state("wrap_n",  1, 32'h108, 1, 0, 32'h110);
    drive(0, 0, 0, 1);         expect_state("wrap_n1", 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_n1.imem_addr", 32'(bus.IMEM_ADDR), 32'h3FFF);
    drive(0, 0, 0, 1);         expect_state("wrap_n2", 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 1);         expect_state("wrap_n3", 1, 32'hFFFF_FFFC, 1, 1, 32'h4);
    chk("wrap_n3.if_pc_4_wrapped", bus.IF_PC_4, 32'h0);
    drive(0, 0, 0, 1);         expect_state("wrap_n4", 1, 32'h0, 1, 1, 32'h8);

    // Reset with a full queue
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);         expect_state("rst_mid",  1, 32'h4, 4, 0, 32'd20);
    drive(0, 0, 0, 1);         expect_state("rst_rel0", 0, 0, 0, 1, RESET_VEC);
    drive(0, 0, 0, 1);         expect_state("rst_rel1", 0, 0, 0, 1, RESET_VEC + 32'd4);
    drive(0, 0, 0, 1);         expect_state("rst_rel2", 1, RESET_VEC, 1, 1, RESET_VEC + 32'd8);

    // Random traffic against the reference model
    drive(1, 0, 0, 0);
    m_q.delete();
    m_fpc  = RESET_VEC;
    m_ipc  = 32'h0;
    m_infl = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        redir, rdy, m_valid, m_rden;
      logic [31:0] rpc;
      redir = ($urandom_range(0, 99) < 6);
      rdy   = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 1) == 0) rpc = 32'($urandom_range(0, 1023));
      else                           rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive(0, redir, rpc, rdy);

      m_valid = (m_q.size() != 0);
      m_rden  = !redir && ((m_q.size() + int'(m_infl)) < DEPTH);
      chk("rnd.valid", 32'(bus.IF_VALID), 32'(m_valid));
      chk("rnd.count", 32'(bus.QUEUE_COUNT), m_q.size());
      chk("rnd.rden", 32'(bus.IMEM_RDEN), 32'(m_rden));
      chk("rnd.fetch_pc", bus.FETCH_PC, m_fpc);
      chk("rnd.imem_addr", 32'(bus.IMEM_ADDR), {18'd0, m_fpc[15:2]});
      if (m_valid) begin
        chk("rnd.if_pc", bus.IF_PC, m_q[0]);
        chk("rnd.if_ir", bus.IF_IR, mem_word(m_q[0][15:2]));
        chk("rnd.if_pc_4", bus.IF_PC_4, m_q[0] + 32'd4);
        if (rdy && !redir)
          $display("accept cyc=%0d pc=%h ir=%h", cyc, bus.IF_PC, bus.IF_IR);
      end else begin
        chk("rnd.if_pc_zero", bus.IF_PC, 32'h0);
        chk("rnd.if_ir_zero", bus.IF_IR, 32'h0);
      end

      if (redir) begin
        m_q.delete();
        m_fpc  = {rpc[31:2], 2'b00};
        m_infl = 1'b0;
      end else begin
        if (m_valid && rdy) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_ipc);
        if (m_rden) begin
          m_ipc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
          m_infl = 1'b1;
        end else begin
          m_infl = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
